// File: rtl/alu_operand_loader.sv
// Operand entry front end for the 4-bit signed ALU: synchronizes and debounces one
// push-button, then steps A -> B -> opcode -> run on each clean press.
module alu_operand_loader #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    input  logic [3:0] sw,
    input  logic [2:0] op_sw,
    output logic [3:0] A,
    output logic [3:0] B,
    output logic [2:0] sel,
    output logic       en,
    output logic [1:0] stage,
    output logic       done
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        LOAD_OP = 2'b10,
        RUN     = 2'b11
    } state_t;

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q;
    logic          db_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          press_q;
    logic          press_d;

    state_t        state_q;
    logic [3:0]    a_q;
    logic [3:0]    b_q;
    logic [2:0]    sel_q;
    logic          en_q;
    logic          done_q;

    // The counter only survives while the synchronized level keeps disagreeing with db.
    always_comb begin
        cnt_d   = '0;
        db_d    = db_q;
        press_d = 1'b0;
        if (sync2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d    = ~db_q;
                press_d = ~db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= 4'd0;
            b_q     <= 4'd0;
            sel_q   <= 3'd0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (press_q) begin
                case (state_q)
                    LOAD_A: begin
                        a_q     <= sw;
                        state_q <= LOAD_B;
                    end
                    LOAD_B: begin
                        b_q     <= sw;
                        state_q <= LOAD_OP;
                    end
                    LOAD_OP: begin
                        sel_q   <= op_sw;
                        en_q    <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= RUN;
                    end
                    RUN: begin
                        en_q    <= 1'b0;
                        state_q <= LOAD_A;
                    end
                    default: state_q <= LOAD_A;
                endcase
            end
        end
    end

    assign A     = a_q;
    assign B     = b_q;
    assign sel   = sel_q;
    assign en    = en_q;
    assign stage = state_q;
    assign done  = done_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with DEBOUNCE_CYCLES=4: vector table plus
// scoreboard of expected register states, and hand-written timing/glitch/reset sequences.
module tb_alu_operand_loader;

    localparam int D = 4;

    typedef struct {
        logic [3:0] sw;
        logic [2:0] opSw;
        logic [3:0] expA;
        logic [3:0] expB;
        logic [2:0] expSel;
        logic       expEn;
        logic [1:0] expStage;
        logic       expDone;
    } rec_t;

    logic       clk;
    logic       rst;
    logic       btn;
    logic [3:0] sw;
    logic [2:0] op_sw;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] sel;
    logic       en;
    logic [1:0] stage;
    logic       done;

    int   checks = 0;
    int   failures = 0;
    rec_t sbQ[$];
    logic [1:0] prevStage;
    int   doneCount = 0;
    int   doneLong = 0;
    int   dbHighCount = 0;
    logic prevDone = 1'b0;

    alu_operand_loader #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst), .btn(btn), .sw(sw), .op_sw(op_sw),
        .A(A), .B(B), .sel(sel), .en(en), .stage(stage), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) doneCount++;
        if (done && prevDone) doneLong++;
        prevDone = done;
        if (dut.db_q) dbHighCount++;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        btn = 1'b0;
        sw = 4'd0;
        op_sw = 3'd0;
        repeat (2) tick();
        rst = 1'b0;
        prevStage = 2'd0;
    endtask

    task automatic checkOutput(input string name);
        rec_t e;
        if (sbQ.size() == 0) begin
            check({name, "_sb_empty"}, 8'd1, 8'd0);
        end else begin
            e = sbQ.pop_front();
            check({name, "_A"}, 8'(A), 8'(e.expA));
            check({name, "_B"}, 8'(B), 8'(e.expB));
            check({name, "_sel"}, 8'(sel), 8'(e.expSel));
            check({name, "_en"}, 8'(en), 8'(e.expEn));
            check({name, "_stage"}, 8'(stage), 8'(e.expStage));
            check({name, "_done"}, 8'(done), 8'(e.expDone));
            prevStage = e.expStage;
        end
    endtask

    // Press starts at the edge after this call (edge k); capture is expected at edge k+6.
    task automatic applyStimulus(input rec_t r, input string name);
        sw = r.sw;
        op_sw = r.opSw;
        btn = 1'b1;
        sbQ.push_back(r);
        repeat (6) tick();
        check({name, "_k5_stage"}, 8'(stage), 8'(prevStage));
        tick();
        checkOutput(name);
        btn = 1'b0;
        repeat (10) tick();
    endtask

    rec_t vec[4];
    rec_t r;
    int   d0;
    int   dbBefore;
    logic [3:0] bounce [9];

    initial begin
        vec[0] = '{sw: 4'd3,     opSw: 3'd0,     expA: 4'd3, expB: 4'd0,     expSel: 3'd0, expEn: 1'b0, expStage: 2'd1, expDone: 1'b0};
        vec[1] = '{sw: 4'b1110,  opSw: 3'd0,     expA: 4'd3, expB: 4'b1110,  expSel: 3'd0, expEn: 1'b0, expStage: 2'd2, expDone: 1'b0};
        vec[2] = '{sw: 4'd0,     opSw: 3'b001,   expA: 4'd3, expB: 4'b1110,  expSel: 3'd1, expEn: 1'b1, expStage: 2'd3, expDone: 1'b1};
        vec[3] = '{sw: 4'd9,     opSw: 3'd6,     expA: 4'd3, expB: 4'b1110,  expSel: 3'd1, expEn: 1'b0, expStage: 2'd0, expDone: 1'b0};
        bounce = '{4'd1, 4'd0, 4'd1, 4'd1, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};

        doReset();
        d0 = doneCount;
        repeat (20) tick();
        check("idle_A", 8'(A), 8'd0);
        check("idle_B", 8'(B), 8'd0);
        check("idle_sel", 8'(sel), 8'd0);
        check("idle_en", 8'(en), 8'd0);
        check("idle_stage", 8'(stage), 8'd0);
        check("idle_done_count", 8'(doneCount - d0), 8'd0);

        // Exact latency and held-button behaviour
        r = '{sw: 4'd3, opSw: 3'd0, expA: 4'd3, expB: 4'd0, expSel: 3'd0, expEn: 1'b0, expStage: 2'd1, expDone: 1'b0};
        sw = 4'd3;
        btn = 1'b1;
        sbQ.push_back(r);
        repeat (6) tick();
        check("lat_k5_stage", 8'(stage), 8'd0);
        check("lat_k5_A", 8'(A), 8'd0);
        tick();
        checkOutput("lat_k6");
        repeat (50) tick();
        check("hold_stage", 8'(stage), 8'd1);
        btn = 1'b0;
        repeat (10) tick();

        // Bounce shorter than D never flips db
        dbBefore = dbHighCount;
        for (int i = 0; i < 9; i++) begin
            btn = bounce[i][0];
            tick();
        end
        btn = 1'b0;
        repeat (10) tick();
        check("bounce_db_never_high", 8'(dbHighCount - dbBefore), 8'd0);
        check("bounce_stage", 8'(stage), 8'd1);

        // Switch movement outside the capture edge is ignored
        for (int j = 0; j < 10; j++) begin
            sw = 4'(j * 7);
            tick();
        end
        check("swtoggle_A", 8'(A), 8'd3);
        check("swtoggle_B", 8'(B), 8'd0);
        r = '{sw: 4'd0, opSw: 3'd0, expA: 4'd3, expB: 4'hF, expSel: 3'd0, expEn: 1'b0, expStage: 2'd2, expDone: 1'b0};
        sbQ.push_back(r);
        for (int j = 0; j <= 6; j++) begin
            sw = 4'(j * 5 + 1);
            btn = 1'b1;
            tick();
            if (j == 5) check("swtoggle_k5_stage", 8'(stage), 8'd1);
        end
        checkOutput("swtoggle_capture");
        btn = 1'b0;
        repeat (10) tick();

        // Full sequence from the vector table
        doReset();
        d0 = doneCount;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vec[i], $sformatf("seq%0d", i));
        end
        check("seq_done_pulses", 8'(doneCount - d0), 8'd1);
        check("seq_done_width", 8'(doneLong), 8'd0);

        // Reset in the middle of a debounce while in LOAD_OP
        doReset();
        applyStimulus(vec[0], "pre0");
        applyStimulus(vec[1], "pre1");
        sw = 4'd7;
        btn = 1'b1;
        repeat (4) tick();
        check("midrst_cnt", 8'(dut.cnt_q), 8'd2);
        check("midrst_pre_stage", 8'(stage), 8'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prevStage = 2'd0;
        check("midrst_A", 8'(A), 8'd0);
        check("midrst_B", 8'(B), 8'd0);
        check("midrst_sel", 8'(sel), 8'd0);
        check("midrst_en", 8'(en), 8'd0);
        check("midrst_stage", 8'(stage), 8'd0);
        r = '{sw: 4'd7, opSw: 3'd0, expA: 4'd7, expB: 4'd0, expSel: 3'd0, expEn: 1'b0, expStage: 2'd1, expDone: 1'b0};
        sbQ.push_back(r);
        repeat (6) tick();
        check("midrst_k5_stage", 8'(stage), 8'd0);
        tick();
        checkOutput("midrst_event");
        repeat (20) tick();
        check("midrst_single_event", 8'(stage), 8'd1);
        btn = 1'b0;
        repeat (10) tick();

        check("sb_drained", 8'(sbQ.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
